// File: rtl/muldiv_sched.sv
// muldiv_sched: schedules per-hart mul/div requests from two harts onto one shared muldiv unit.
// Build option: define MULDIV_SCHED_RR_EN for round-robin arbitration; the default is fixed priority with hart0 first.
module muldiv_sched #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [5:0]        i_req_op,
  input  logic [2*XLEN-1:0] i_req_a,
  input  logic [2*XLEN-1:0] i_req_b,
  input  logic [2*RD_W-1:0] i_req_rd,
  input  logic [1:0]        i_flush,
  output logic              o_md_start,
  output logic [2:0]        o_md_op,
  output logic [XLEN-1:0]   o_md_a,
  output logic [XLEN-1:0]   o_md_b,
  output logic              o_md_hart_id,
  output logic [RD_W-1:0]   o_md_rd,
  input  logic              i_md_busy,
  input  logic              i_md_done,
  input  logic [XLEN-1:0]   i_md_result,
  output logic [1:0]        o_rsp_valid,
  output logic [RD_W-1:0]   o_rsp_rd,
  output logic [XLEN-1:0]   o_rsp_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_full;
  logic [2:0] r_op [2];
  logic [XLEN-1:0] r_a [2];
  logic [XLEN-1:0] r_b [2];
  logic [RD_W-1:0] r_rd [2];
  logic r_win, r_kill;
  logic [RD_W-1:0] r_inf_rd;
  logic [1:0] r_rsp_valid;
  logic [RD_W-1:0] r_rsp_rd;
  logic [XLEN-1:0] r_rsp_result;
  logic [1:0] w_vld, w_cap;
  logic w_sel, w_start, w_done;

  assign w_vld = r_full & ~i_flush;
  assign o_req_ready = {2{rst_n}} & ~r_full & ~i_flush;
  assign w_cap = i_req_valid & o_req_ready;

`ifdef MULDIV_SCHED_RR_EN
  logic r_ptr;
  // round-robin pointer: after each issue the other hart wins the next tie
  always_ff @(posedge clk) r_ptr <= !rst_n ? 1'b0 : w_start ? ~r_win : r_ptr;
  assign w_sel = &w_vld ? r_ptr : ~w_vld[0];
`else
  assign w_sel = ~w_vld[0];
`endif

  // state register
  always_ff @(posedge clk) r_state <= rst_n ? w_next : IDLE;

  // next state: a flushed winner abandons the issue and goes back to IDLE
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && |w_vld && !i_md_busy) w_next = ISSUE;
    if (r_state == ISSUE) w_next = i_flush[r_win] ? IDLE : WAIT;
    if (r_state == WAIT && i_md_done) w_next = IDLE;
  end

  // FSM outputs: start pulse in ISSUE unless the winner is flushed, done only counts in WAIT
  always_comb begin
    w_start = rst_n && r_state == ISSUE && !i_flush[r_win];
    w_done = r_state == WAIT && i_md_done;
  end

  assign o_md_start = w_start;
  assign o_md_op = w_start ? r_op[r_win] : '0;
  assign o_md_a = w_start ? r_a[r_win] : '0;
  assign o_md_b = w_start ? r_b[r_win] : '0;
  assign o_md_rd = w_start ? r_rd[r_win] : '0;
  assign o_md_hart_id = w_start & r_win;

  // request slots: fill on handshake, empty on flush or when the slot leaves through ISSUE
  always_ff @(posedge clk) begin
    for (int h = 0; h < 2; h++) begin
      if (!rst_n) r_full[h] <= 1'b0;
      else if (i_flush[h] || (r_state == ISSUE && r_win == 1'(h))) r_full[h] <= 1'b0;
      else if (w_cap[h]) r_full[h] <= 1'b1;
      if (w_cap[h]) begin
        r_op[h] <= i_req_op[3*h +: 3];
        r_a[h] <= i_req_a[XLEN*h +: XLEN];
        r_b[h] <= i_req_b[XLEN*h +: XLEN];
        r_rd[h] <= i_req_rd[RD_W*h +: RD_W];
      end
    end
  end

  // winner selection and in-flight bookkeeping; the slot may refill during WAIT so rd is kept here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win <= 1'b0;
      r_kill <= 1'b0;
      r_inf_rd <= '0;
    end else begin
      if (r_state == IDLE) r_win <= w_sel;
      if (w_start) r_inf_rd <= r_rd[r_win];
      r_kill <= w_start ? 1'b0 : (r_kill || (r_state == WAIT && i_flush[r_win]));
    end
  end

  // writeback: one-cycle response per completed op, swallowed if the op was killed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rd <= '0;
      r_rsp_result <= '0;
    end else begin
      r_rsp_valid <= (w_done && !r_kill && !i_flush[r_win]) ? (2'b01 << r_win) : 2'b00;
      if (w_done) begin
        r_rsp_rd <= r_inf_rd;
        r_rsp_result <= i_md_result;
      end
    end
  end

  assign o_rsp_valid = rst_n ? r_rsp_valid : '0;
  assign o_rsp_rd = rst_n ? r_rsp_rd : '0;
  assign o_rsp_result = rst_n ? r_rsp_result : '0;
endmodule
